ram_bus_port: RTL and testbench

// - Upstream front-end for the SoC word RAM: accepts core load/store requests on a valid/ready bus.
// - Drives the RAM's synchronous byte-write / registered-read port and returns one response per request.
// - Decodes the address window, flags out-of-range accesses, and holds responses under backpressure.
// - One request in flight; back-to-back issue sustains 1 request/cycle when rsp_ready stays high.

---
 rtl/soc_pkg.sv | 14 +
 rtl/ram.sv | 27 ++
 rtl/ram_bus_port.sv | 101 ++++++++++
 tb/tb_ram_bus_port.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// Shared types and helpers for the SoC word-RAM bus front-end.
package soc_pkg;

  typedef enum logic [0:0] {RP_IDLE, RP_RSP} rp_state_e;

  // True when the byte address falls inside the DEPTH-word window starting at base.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input int unsigned depth);
    logic [31:0] off;
    off = addr - base;
    return (off >> 2) < depth;
  endfunction

endpackage

// File: rtl/ram.sv
// Word RAM with per-byte synchronous write and registered read.
module ram #(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   din,
  input  logic          ren,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   dout
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wen[b]) mem[waddr][8*b +: 8] <= din[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (ren) dout <= mem[raddr];
  end

endmodule

// File: rtl/ram_bus_port.sv
// Valid/ready load/store front-end for the word RAM; one request in flight, one response each.
module ram_bus_port
  import soc_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  input  logic          req_we,
  input  logic [3:0]    req_wstrb,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] ram_waddr,
  output logic [3:0]    ram_wen,
  output logic [31:0]   ram_din,
  output logic          ram_ren,
  output logic [AW-1:0] ram_raddr,
  input  logic [31:0]   ram_dout
);

  rp_state_e   state_q, state_d;
  logic        is_rd_q, is_rd_d;
  logic        err_q, err_d;
  logic        accept;
  logic        in_range;
  logic [31:0] off;
  logic [AW-1:0] index;

  assign off      = req_addr - BASE_ADDR;
  assign index    = AW'(off >> 2);
  assign in_range = in_window(req_addr, BASE_ADDR, DEPTH);

  // Issue is allowed in the same cycle the pending response retires.
  assign req_ready = (state_q == RP_IDLE) || rsp_ready;
  assign accept    = req_valid && req_ready;

  // RAM is only driven in the accept cycle; reset gates it so no partial write can occur.
  assign ram_waddr = index;
  assign ram_raddr = index;
  assign ram_din   = req_wdata;
  assign ram_wen   = (rst_n && accept && req_we && in_range) ? req_wstrb : 4'b0000;
  assign ram_ren   = rst_n && accept && !req_we && in_range;

  always_comb begin
    state_d = state_q;
    is_rd_d = is_rd_q;
    err_d   = err_q;
    case (state_q)
      RP_IDLE: begin
        if (accept) begin
          state_d = RP_RSP;
          is_rd_d = !req_we && in_range;
          err_d   = !in_range;
        end
      end
      RP_RSP: begin
        if (rsp_ready) begin
          if (accept) begin
            is_rd_d = !req_we && in_range;
            err_d   = !in_range;
          end else begin
            state_d = RP_IDLE;
            is_rd_d = 1'b0;
            err_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = RP_IDLE;
        is_rd_d = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RP_IDLE;
      is_rd_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_rd_q <= is_rd_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == RP_RSP);
  assign rsp_err   = err_q;
  // ram_dout only changes on a new read, so this stays stable while stalled.
  assign rsp_rdata = is_rd_q ? ram_dout : 32'h0;

endmodule

// File: tb/tb_ram_bus_port.sv
// Directed bench for ram_bus_port + ram, with a queue-based transaction model checked every cycle.
module tb_ram_bus_port;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [31:0]   req_addr, req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [3:0]    ram_wen;
  logic [31:0]   ram_din, ram_dout;
  logic          ram_ren;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_bus_port #(.DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_waddr(ram_waddr), .ram_wen(ram_wen), .ram_din(ram_din),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );

  ram #(.DEPTH(DEPTH)) u_ram (
    .clk(clk), .wen(ram_wen), .waddr(ram_waddr), .din(ram_din),
    .ren(ram_ren), .raddr(ram_raddr), .dout(ram_dout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct {logic err; logic [31:0] rdata;} rsp_t;
  rsp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];

  initial for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;

  function automatic logic m_in_range(input logic [31:0] a);
    return a < DEPTH * 4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      logic busy, acc;
      rsp_t r;
      busy = exp_q.size() != 0;
      acc  = req_valid && (!busy || rsp_ready);
      if (busy && rsp_ready) void'(exp_q.pop_front());
      if (acc) begin
        r.err   = !m_in_range(req_addr);
        r.rdata = 32'h0;
        if (!r.err && !req_we) r.rdata = mem_m[req_addr / 4];
        if (!r.err && req_we)
          for (int b = 0; b < 4; b++)
            if (req_wstrb[b]) mem_m[req_addr / 4][8*b +: 8] = req_wdata[8*b +: 8];
        exp_q.push_back(r);
      end
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    logic busy, acc, inr;
    busy = exp_q.size() != 0;
    acc  = rst_n && req_valid && (!busy || rsp_ready);
    inr  = m_in_range(req_addr);
    chk("rsp_valid", 32'(rsp_valid), 32'(busy));
    chk("req_ready", 32'(req_ready), 32'(!busy || rsp_ready));
    chk("rsp_err", 32'(rsp_err), busy ? 32'(exp_q[0].err) : 32'h0);
    chk("rsp_rdata", rsp_rdata, busy ? exp_q[0].rdata : 32'h0);
    chk("ram_ren", 32'(ram_ren), 32'(acc && !req_we && inr));
    chk("ram_wen", 32'(ram_wen), (acc && req_we && inr) ? 32'(req_wstrb) : 32'h0);
    if (acc && inr) begin
      chk("ram_raddr", 32'(ram_raddr), req_addr / 4);
      chk("ram_waddr", 32'(ram_waddr), req_addr / 4);
      if (req_we) chk("ram_din", ram_din, req_wdata);
    end
  end

  // ---------------- stimulus ----------------
  // Presents one request and returns just after its accept edge.
  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] strb,
                       input logic [31:0] data);
    int waited = 0;
    req_valid = 1'b1; req_addr = addr; req_we = we; req_wstrb = strb; req_wdata = data;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: req_ready got 0 expected 1 for addr %h", addr);
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic rsp_lit(input string name, input logic err, input logic [31:0] rdata);
    chk({name, "_valid"}, 32'(rsp_valid), 32'h1);
    chk({name, "_err"}, 32'(rsp_err), 32'(err));
    chk({name, "_rdata"}, rsp_rdata, rdata);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #2;
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b1; req_wstrb = 4'hF;
    req_wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_ram_wen", 32'(ram_wen), 32'h0);
    #1;
    rst_n = 1'b1; req_valid = 1'b0;
    idle_cycle();

    // full store then load
    issue(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
    rsp_lit("st_full", 1'b0, 32'h0);
    issue(32'h10, 1'b0, 4'h0, 32'h0);
    rsp_lit("ld_full", 1'b0, 32'hDEAD_BEEF);

    // partial byte store
    issue(32'h10, 1'b1, 4'b0001, 32'h0000_00AA);
    issue(32'h10, 1'b0, 4'h0, 32'h0);
    rsp_lit("ld_byte", 1'b0, 32'hDEAD_BEAA);

    // zero-strobe store writes nothing
    issue(32'h13, 1'b1, 4'b0000, 32'h1122_3344);
    rsp_lit("st_nostrb", 1'b0, 32'h0);
    issue(32'h12, 1'b0, 4'h0, 32'h0);
    rsp_lit("ld_nostrb", 1'b0, 32'hDEAD_BEAA);
    idle_cycle();

    // stalled response with a queued request behind it
    rsp_ready = 1'b0;
    issue(32'h10, 1'b0, 4'h0, 32'h0);
    req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_rdata", rsp_rdata, 32'hDEAD_BEAA);
      chk("stall_ready", 32'(req_ready), 32'h0);
      chk("stall_ren", 32'(ram_ren), 32'h0);
    end
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    rsp_lit("after_stall", 1'b0, 32'hDEAD_BEAA);

    // out-of-range accesses must not alias onto word 0
    issue(32'h0, 1'b1, 4'hF, 32'h1234_5678);
    issue(32'h400, 1'b0, 4'h0, 32'h0);
    rsp_lit("ld_oor", 1'b1, 32'h0);
    issue(32'h400, 1'b1, 4'hF, 32'h5555_5555);
    rsp_lit("st_oor", 1'b1, 32'h0);
    issue(32'h0, 1'b0, 4'h0, 32'h0);
    rsp_lit("ld_word0", 1'b0, 32'h1234_5678);
    issue(32'h3FC, 1'b1, 4'hF, 32'hCAFE_0001);
    rsp_lit("st_top", 1'b0, 32'h0);

    // back-to-back loads
    for (int i = 0; i < 4; i++) issue(32'h20 + 4 * i, 1'b1, 4'hF, 32'hA000_0000 + i);
    for (int i = 0; i < 4; i++) begin
      issue(32'h20 + 4 * i, 1'b0, 4'h0, 32'h0);
      rsp_lit("b2b", 1'b0, 32'hA000_0000 + i);
    end
    issue(32'h3FC, 1'b0, 4'h0, 32'h0);
    rsp_lit("ld_top", 1'b0, 32'hCAFE_0001);
    idle_cycle();

    // reset while a response is stalled
    rsp_ready = 1'b0;
    issue(32'h20, 1'b0, 4'h0, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1; rsp_ready = 1'b1;
    idle_cycle();
    issue(32'h10, 1'b0, 4'h0, 32'h0);
    rsp_lit("post_rst_ld10", 1'b0, 32'hDEAD_BEAA);
    issue(32'h2C, 1'b0, 4'h0, 32'h0);
    rsp_lit("post_rst_ld2c", 1'b0, 32'hA000_0003);
    idle_cycle();
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
